// File: rtl/mips_decode_stage.sv
// MIPS decode stage: one-entry output register holding decoded fields.
// Stalls MDU-class ops while a multiply/divide is still in flight.
module mips_decode_stage #(
    parameter int ENABLE_MDU = 1,
    parameter int ENABLE_EXT = 1,
    parameter int MUL_LAT    = 5,
    parameter int DIV_LAT    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_op,
    output logic [4:0]  out_rs,
    output logic [4:0]  out_rt,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_shamt,
    output logic [15:0] out_imm16,
    output logic        out_illegal,
    output logic        out_mdu_busy
);

    localparam int MAXLAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW     = $clog2(MAXLAT + 1);
    localparam logic [CW-1:0] MUL_LD = CW'(MUL_LAT);
    localparam logic [CW-1:0] DIV_LD = CW'(DIV_LAT);
    localparam bit MDU_ON = (ENABLE_MDU != 0);
    localparam bit EXT_ON = (ENABLE_EXT != 0);

    logic [5:0]    opc;
    logic [5:0]    fn;
    logic [4:0]    rtf;
    logic [5:0]    dop;
    logic [CW-1:0] cnt;
    logic          mdu_in;
    logic          held_mul;
    logic          held_div;
    logic          stall;
    logic          handoff;
    logic          accept;

    assign opc = in_instr[31:26];
    assign fn  = in_instr[5:0];
    assign rtf = in_instr[20:16];

    // Opcode/funct to op index; disabled groups fall through to 0.
    always_comb begin
        dop = 6'd0;
        case (opc)
            6'h00: begin
                case (fn)
                    6'h00: dop = 6'd28;
                    6'h02: dop = 6'd29;
                    6'h03: dop = 6'd30;
                    6'h04: dop = 6'd31;
                    6'h06: dop = 6'd32;
                    6'h07: dop = 6'd33;
                    6'h08: dop = 6'd10;
                    6'h09: dop = 6'd11;
                    6'h10: dop = MDU_ON ? 6'd47 : 6'd0;
                    6'h11: dop = MDU_ON ? 6'd49 : 6'd0;
                    6'h12: dop = MDU_ON ? 6'd48 : 6'd0;
                    6'h13: dop = MDU_ON ? 6'd50 : 6'd0;
                    6'h18: dop = MDU_ON ? 6'd43 : 6'd0;
                    6'h19: dop = MDU_ON ? 6'd44 : 6'd0;
                    6'h1A: dop = MDU_ON ? 6'd45 : 6'd0;
                    6'h1B: dop = MDU_ON ? 6'd46 : 6'd0;
                    6'h20: dop = 6'd18;
                    6'h21: dop = 6'd1;
                    6'h22: dop = 6'd19;
                    6'h23: dop = 6'd2;
                    6'h24: dop = 6'd20;
                    6'h25: dop = 6'd21;
                    6'h26: dop = 6'd22;
                    6'h27: dop = 6'd23;
                    6'h2A: dop = 6'd34;
                    6'h2B: dop = 6'd37;
                    default: dop = 6'd0;
                endcase
            end
            6'h01: begin
                if (rtf == 5'd0)
                    dop = 6'd41;
                else if (rtf == 5'd1)
                    dop = 6'd42;
            end
            6'h02: dop = 6'd8;
            6'h03: dop = 6'd9;
            6'h04: dop = 6'd7;
            6'h05: dop = 6'd38;
            6'h06: dop = 6'd39;
            6'h07: dop = 6'd40;
            6'h08: dop = 6'd25;
            6'h09: dop = 6'd24;
            6'h0A: dop = 6'd35;
            6'h0B: dop = 6'd36;
            6'h0C: dop = 6'd26;
            6'h0D: dop = 6'd3;
            6'h0E: dop = 6'd27;
            6'h0F: dop = 6'd4;
            6'h1C: begin
                if (EXT_ON && fn == 6'h00)
                    dop = 6'd51;
                else if (EXT_ON && fn == 6'h20)
                    dop = 6'd52;
            end
            6'h20: dop = 6'd16;
            6'h21: dop = 6'd14;
            6'h23: dop = 6'd5;
            6'h24: dop = 6'd17;
            6'h25: dop = 6'd15;
            6'h28: dop = 6'd13;
            6'h29: dop = 6'd12;
            6'h2B: dop = 6'd6;
            6'h3F: begin
                if (EXT_ON && fn == 6'h00)
                    dop = 6'd53;
            end
            default: dop = 6'd0;
        endcase
    end

    assign mdu_in   = (dop >= 6'd43) && (dop <= 6'd51);
    assign held_mul = out_valid &&
                      (out_op == 6'd43 || out_op == 6'd44 || out_op == 6'd51);
    assign held_div = out_valid && (out_op == 6'd45 || out_op == 6'd46);
    assign stall    = mdu_in && ((cnt != '0) || held_mul || held_div);
    assign in_ready = (!out_valid || out_ready) && !flush && !stall;
    assign handoff  = out_valid && out_ready && !flush;
    assign accept   = in_valid && in_ready;
    assign out_mdu_busy = (cnt != '0);

    // Busy counter: reload on long-op handoff, otherwise count down to 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (handoff && held_mul)
            cnt <= MUL_LD;
        else if (handoff && held_div)
            cnt <= DIV_LD;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    // Output record: load on accept, drop on flush or handoff.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            out_op      <= 6'd0;
            out_illegal <= 1'b0;
            out_rs      <= 5'd0;
            out_rt      <= 5'd0;
            out_rd      <= 5'd0;
            out_shamt   <= 5'd0;
            out_imm16   <= 16'd0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_op      <= dop;
            out_illegal <= (dop == 6'd0);
            out_rs      <= in_instr[25:21];
            out_rt      <= in_instr[20:16];
            out_rd      <= in_instr[15:11];
            out_shamt   <= in_instr[10:6];
            out_imm16   <= in_instr[15:0];
        end else if (flush || handoff) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_decode_stage.sv
// Bench for mips_decode_stage: three parameter variants against a
// table-driven reference model, directed scenarios then random traffic.
module tb_mips_decode_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = 32'd0;

    logic        rdy[3];
    logic        ov[3];
    logic        ill[3];
    logic        busy[3];
    logic [5:0]  op[3];
    logic [4:0]  rs[3];
    logic [4:0]  rt[3];
    logic [4:0]  rd[3];
    logic [4:0]  sh[3];
    logic [15:0] imm[3];

    int ncmp = 0;
    int nfail = 0;

    int en_mdu[3] = '{1, 1, 0};
    int en_ext[3] = '{1, 0, 1};
    int mlat[3]   = '{5, 5, 3};
    int dlat[3]   = '{10, 10, 2};

    int rtab[64];
    int itab[64];

    bit          mv[3];
    int          mop[3];
    bit          mill[3];
    logic [31:0] mins[3];
    int          mcnt[3];

    always #5 clk = ~clk;

    mips_decode_stage u0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_instr(in_instr), .flush(flush), .out_valid(ov[0]),
        .out_ready(out_ready), .out_op(op[0]), .out_rs(rs[0]),
        .out_rt(rt[0]), .out_rd(rd[0]), .out_shamt(sh[0]),
        .out_imm16(imm[0]), .out_illegal(ill[0]), .out_mdu_busy(busy[0])
    );

    mips_decode_stage #(.ENABLE_EXT(0)) u1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_instr(in_instr), .flush(flush), .out_valid(ov[1]),
        .out_ready(out_ready), .out_op(op[1]), .out_rs(rs[1]),
        .out_rt(rt[1]), .out_rd(rd[1]), .out_shamt(sh[1]),
        .out_imm16(imm[1]), .out_illegal(ill[1]), .out_mdu_busy(busy[1])
    );

    mips_decode_stage #(.ENABLE_MDU(0), .MUL_LAT(3), .DIV_LAT(2)) u2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_instr(in_instr), .flush(flush), .out_valid(ov[2]),
        .out_ready(out_ready), .out_op(op[2]), .out_rs(rs[2]),
        .out_rt(rt[2]), .out_rd(rd[2]), .out_shamt(sh[2]),
        .out_imm16(imm[2]), .out_illegal(ill[2]), .out_mdu_busy(busy[2])
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void init_tables();
        for (int k = 0; k < 64; k++) begin
            rtab[k] = 0;
            itab[k] = 0;
        end
        rtab[0] = 28;  rtab[2] = 29;  rtab[3] = 30;  rtab[4] = 31;
        rtab[6] = 32;  rtab[7] = 33;  rtab[8] = 10;  rtab[9] = 11;
        rtab[16] = 47; rtab[17] = 49; rtab[18] = 48; rtab[19] = 50;
        rtab[24] = 43; rtab[25] = 44; rtab[26] = 45; rtab[27] = 46;
        rtab[32] = 18; rtab[33] = 1;  rtab[34] = 19; rtab[35] = 2;
        rtab[36] = 20; rtab[37] = 21; rtab[38] = 22; rtab[39] = 23;
        rtab[42] = 34; rtab[43] = 37;
        itab[2] = 8;   itab[3] = 9;   itab[4] = 7;   itab[5] = 38;
        itab[6] = 39;  itab[7] = 40;  itab[8] = 25;  itab[9] = 24;
        itab[10] = 35; itab[11] = 36; itab[12] = 26; itab[13] = 3;
        itab[14] = 27; itab[15] = 4;  itab[32] = 16; itab[33] = 14;
        itab[35] = 5;  itab[36] = 17; itab[37] = 15; itab[40] = 13;
        itab[41] = 12; itab[43] = 6;
    endfunction

    function automatic int ref_op(logic [31:0] w, int i);
        int o, f, r, res;
        o = int'(w[31:26]);
        f = int'(w[5:0]);
        r = int'(w[20:16]);
        if (o == 0)
            res = rtab[f];
        else if (o == 1)
            res = (r == 0) ? 41 : (r == 1) ? 42 : 0;
        else if (o == 28)
            res = (f == 0) ? 51 : (f == 32) ? 52 : 0;
        else if (o == 63)
            res = (f == 0) ? 53 : 0;
        else
            res = itab[o];
        if (en_mdu[i] == 0 && res >= 43 && res <= 50) res = 0;
        if (en_ext[i] == 0 && res >= 51) res = 0;
        return res;
    endfunction

    function automatic bit m_rdy(int i);
        int d;
        bit mdu, held, st;
        d = ref_op(in_instr, i);
        mdu = (d >= 43 && d <= 51);
        held = mv[i] && (mop[i] inside {43, 44, 45, 46, 51});
        st = mdu && (mcnt[i] > 0 || held);
        return (!mv[i] || out_ready) && !flush && !st;
    endfunction

    function automatic void m_zero();
        for (int i = 0; i < 3; i++) begin
            mv[i] = 0; mop[i] = 0; mill[i] = 0; mins[i] = 0; mcnt[i] = 0;
        end
    endfunction

    function automatic void m_step(int i);
        bit r, ho;
        int d;
        if (!reset) begin
            mv[i] = 0; mop[i] = 0; mill[i] = 0; mins[i] = 0; mcnt[i] = 0;
            return;
        end
        r = m_rdy(i);
        ho = mv[i] && out_ready && !flush;
        d = ref_op(in_instr, i);
        if (ho && (mop[i] inside {43, 44, 51}))
            mcnt[i] = mlat[i];
        else if (ho && (mop[i] inside {45, 46}))
            mcnt[i] = dlat[i];
        else if (mcnt[i] > 0)
            mcnt[i] = mcnt[i] - 1;
        if (in_valid && r) begin
            mv[i] = 1; mop[i] = d; mill[i] = (d == 0); mins[i] = in_instr;
        end else if (flush || ho) begin
            mv[i] = 0;
        end
    endfunction

    task automatic check_all();
        logic [31:0] w;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d.in_ready", i), rdy[i], m_rdy(i));
            chk($sformatf("u%0d.out_valid", i), ov[i], mv[i]);
            chk($sformatf("u%0d.busy", i), busy[i], mcnt[i] > 0);
            if (mv[i]) begin
                w = mins[i];
                chk($sformatf("u%0d.op", i), op[i], mop[i]);
                chk($sformatf("u%0d.illegal", i), ill[i], mill[i]);
                chk($sformatf("u%0d.rs", i), rs[i], w[25:21]);
                chk($sformatf("u%0d.rt", i), rt[i], w[20:16]);
                chk($sformatf("u%0d.rd", i), rd[i], w[15:11]);
                chk($sformatf("u%0d.shamt", i), sh[i], w[10:6]);
                chk($sformatf("u%0d.imm16", i), imm[i], w[15:0]);
            end
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        check_all();
    endtask

    task automatic go();
        for (int i = 0; i < 3; i++) m_step(i);
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        at_neg();
        go();
    endtask

    task automatic chk_zero(string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.u%0d.out_valid", tag, i), ov[i], 0);
            chk($sformatf("%s.u%0d.op", tag, i), op[i], 0);
            chk($sformatf("%s.u%0d.illegal", tag, i), ill[i], 0);
            chk($sformatf("%s.u%0d.fields", tag, i),
                {rs[i], rt[i], rd[i], sh[i]}, 0);
            chk($sformatf("%s.u%0d.imm16", tag, i), imm[i], 0);
            chk($sformatf("%s.u%0d.busy", tag, i), busy[i], 0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        m_zero();
        #1;
        chk_zero("rst_async");
        tick();
        reset = 1'b1;
        flush = 1'b0;
        at_neg();
        chk("rst_release.in_ready", rdy[0], 1);
        go();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int s;
        logic [5:0] mf[8];
        mf = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B};
        w = $urandom;
        s = $urandom_range(0, 9);
        if (s <= 3) begin
            w[31:26] = 6'h00;
        end else if (s == 4) begin
            w[31:26] = 6'h00;
            w[5:0] = mf[$urandom_range(0, 7)];
        end else if (s == 5) begin
            w[31:26] = 6'h1C;
            w[5:0] = ($urandom_range(0, 2) == 0) ? 6'h20 :
                     ($urandom_range(0, 1) == 0) ? 6'h00 : w[5:0];
        end else if (s == 6) begin
            w[31:26] = 6'h01;
            w[20:16] = 5'($urandom_range(0, 3));
        end else if (s == 7) begin
            w[31:26] = 6'h3F;
            if ($urandom_range(0, 1) == 0) w[5:0] = 6'h00;
        end
        return w;
    endfunction

    initial begin
        init_tables();
        m_zero();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("por");
        reset = 1'b1;
        at_neg();
        chk("por_release.in_ready", rdy[0], 1);
        go();

        in_instr = 32'h34A500FF; in_valid = 1; out_ready = 1;
        tick();
        in_valid = 0;
        at_neg();
        chk("ori.valid", ov[0], 1);
        chk("ori.op", op[0], 3);
        chk("ori.rs", rs[0], 5);
        chk("ori.rt", rt[0], 5);
        chk("ori.imm16", imm[0], 16'h00FF);
        chk("ori.illegal", ill[0], 0);
        go();

        in_instr = 32'h0; in_valid = 1;
        tick();
        in_valid = 0;
        at_neg();
        chk("nop.op", op[0], 28);
        go();

        in_instr = 32'h00220018; in_valid = 1; out_ready = 1;
        tick();
        in_instr = 32'h00001812;
        at_neg();
        chk("mult_held.in_ready", rdy[0], 0);
        chk("mult_held.op", op[0], 43);
        go();
        for (int k = 1; k <= 5; k++) begin
            at_neg();
            chk($sformatf("mflo_stall_T+%0d", k), rdy[0], 0);
            go();
        end
        at_neg();
        chk("mflo_T+6.in_ready", rdy[0], 1);
        go();
        in_valid = 0;
        at_neg();
        chk("mflo.op", op[0], 48);
        chk("mflo.rd", rd[0], 3);
        go();
        repeat (12) tick();

        in_instr = 32'h00221821; in_valid = 1; out_ready = 0;
        tick();
        in_instr = 32'h8C430004;
        for (int k = 0; k < 3; k++) begin
            at_neg();
            chk("hold.in_ready", rdy[0], 0);
            chk("hold.op", op[0], 1);
            chk("hold.rd", rd[0], 3);
            go();
        end
        out_ready = 1;
        at_neg();
        chk("release.in_ready", rdy[0], 1);
        go();
        in_valid = 0;
        at_neg();
        chk("b2b.op", op[0], 5);
        chk("b2b.valid", ov[0], 1);
        go();

        in_instr = 32'h0022001A; in_valid = 1;
        tick();
        flush = 1; in_instr = 32'h34A500FF;
        at_neg();
        chk("flush.in_ready", rdy[0], 0);
        go();
        flush = 0; in_valid = 0;
        at_neg();
        chk("flush.valid", ov[0], 0);
        chk("flush.busy", busy[0], 0);
        go();

        in_instr = 32'h0022001A; in_valid = 1; out_ready = 1;
        tick();
        in_instr = 32'h00221821;
        tick();
        in_valid = 0; out_ready = 0;
        repeat (3) tick();
        chk("cnt7.busy", busy[0], 1);
        chk("cnt7.valid", ov[0], 1);
        do_reset();

        in_instr = 32'h70221020; in_valid = 1; out_ready = 1;
        tick();
        in_valid = 0;
        at_neg();
        chk("clz_noext.op", op[1], 0);
        chk("clz_noext.illegal", ill[1], 1);
        chk("clz_noext.rs", rs[1], 1);
        chk("clz_noext.rt", rt[1], 2);
        chk("clz_noext.rd", rd[1], 2);
        chk("clz_ext.op", op[0], 52);
        chk("clz_ext.illegal", ill[0], 0);
        go();

        for (int n = 0; n < 1500; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 11) == 0);
            in_instr = rand_instr();
            if (n == 700)
                do_reset();
            else
                tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
